if_fetch_unit: RTL and testbench

- Fetch-side companion to the PC register.
- Consumes the current PC, issues instruction-memory requests, buffers returned instructions with their PCs in an in-order queue, and presents them to the IF/ID stage with a valid/ready handshake.
- Computes the next PC and the PC-register stall, and handles redirects (branch/jump/exception) by flushing the queue and discarding in-flight responses.

---
 rtl/if_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Fetch-side companion to the PC register. Issues instruction-memory requests
// for the current PC and buffers the returned words with their PCs in an
// in-order queue. It presents the queue head to the IF/ID stage with a
// valid/ready handshake and produces the next PC and the PC-register stall.
// A redirect flushes the queue, and responses that were already in flight
// are discarded when they return.
//
// Ports:
//   CLOCK            in   1   clock, all state on the rising edge
//   RESET            in   1   synchronous, active-high reset
//   PC_Cur           in  32   current PC from the PC register
//   PC_Next          out 32   next PC for the PC register input
//   PC_Stall         out  1   hold the PC register
//   IMEM_Req         out  1   instruction-memory request valid
//   IMEM_Addr        out 32   request address (equals PC_Cur)
//   IMEM_Gnt         in   1   request accepted this cycle
//   IMEM_Rvalid      in   1   read data valid (in order, latency >= 1)
//   IMEM_Rdata       in  32   instruction word
//   Redirect         in   1   control-flow change, flush the fetch path
//   Redirect_Target  in  32   new PC (bits [1:0] are forced to zero)
//   ID_Valid         out  1   head instruction available
//   ID_Ready         in   1   decode accepts the head this cycle
//   ID_Instr         out 32   head instruction word
//   ID_PC            out 32   PC of the head instruction
// ============================================================================
module if_fetch_unit #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [31:0] PC_Cur,
   output logic [31:0] PC_Next,
   output logic        PC_Stall,
   output logic        IMEM_Req,
   output logic [31:0] IMEM_Addr,
   input  logic        IMEM_Gnt,
   input  logic        IMEM_Rvalid,
   input  logic [31:0] IMEM_Rdata,
   input  logic        Redirect,
   input  logic [31:0] Redirect_Target,
   output logic        ID_Valid,
   input  logic        ID_Ready,
   output logic [31:0] ID_Instr,
   output logic [31:0] ID_PC
);

   localparam int CNT_W = PTR_W + 1;
   // The discard counter accumulates across back-to-back redirects, so it is
   // given headroom beyond one queue's worth of outstanding requests.
   localparam int DROP_W = PTR_W + 4;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Queue storage: PC and instruction per entry plus a filled flag.
   logic [31:0]       q_pc    [DEPTH];
   logic [31:0]       q_instr [DEPTH];
   logic [DEPTH-1:0]  q_filled;

   // Allocation, fill and read pointers walk the ring in the same order.
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  fill_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Allocated entries, entries still waiting for data, stale responses.
   logic [CNT_W-1:0]  alloc_cnt;
   logic [CNT_W-1:0]  unfilled_cnt;
   logic [DROP_W-1:0] drop_cnt;

   logic              queue_full;
   logic              issue;
   logic              pop;
   logic              fill_ok;
   logic              drop_dec;
   logic [DROP_W-1:0] redirect_sum;
   logic [DROP_W-1:0] redirect_drop;

   // Request, handshake and response classification. Issue looks only at
   // the registered allocation count, so a pop in the same cycle does not
   // open a slot until the next cycle.
   always_comb begin
      queue_full = (alloc_cnt == DEPTH_C);
      IMEM_Req   = !RESET && !Redirect && !queue_full;
      IMEM_Addr  = PC_Cur;
      issue      = IMEM_Req && IMEM_Gnt;

      ID_Valid   = q_filled[rd_ptr] && !Redirect && !RESET;
      ID_Instr   = q_instr[rd_ptr];
      ID_PC      = q_pc[rd_ptr];
      pop        = ID_Valid && ID_Ready;

      // A response with nothing waiting for it and nothing to discard is a
      // protocol error and is simply ignored.
      fill_ok    = IMEM_Rvalid && !Redirect && (drop_cnt == '0) && (unfilled_cnt != '0);
      drop_dec   = IMEM_Rvalid && !Redirect && (drop_cnt != '0);
   end

   // Discard count after a redirect: every response still owed to the
   // flushed entries becomes stale. A response arriving in the redirect
   // cycle is itself one of those owed words and is thrown away on the
   // spot, so it is taken off the total rather than being dropped twice.
   always_comb begin
      redirect_sum  = drop_cnt + DROP_W'(unfilled_cnt);
      redirect_drop = redirect_sum;
      if (IMEM_Rvalid && (redirect_sum != '0)) begin
         redirect_drop = redirect_sum - DROP_W'(1);
      end
   end

   // Next-PC selection. The redirect target is word aligned here so the PC
   // register never sees a misaligned address. During reset the PC register
   // is held.
   always_comb begin
      PC_Next  = PC_Cur + 32'd4;
      PC_Stall = !issue;
      if (Redirect) begin
         PC_Next  = {Redirect_Target[31:2], 2'b00};
         PC_Stall = 1'b0;
      end
      if (RESET) begin
         PC_Stall = 1'b1;
      end
   end

   // Control state: pointers, counters and filled flags. A redirect empties
   // the queue in one cycle and suppresses issue and pop for that cycle.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         wr_ptr       <= '0;
         fill_ptr     <= '0;
         rd_ptr       <= '0;
         alloc_cnt    <= '0;
         unfilled_cnt <= '0;
         drop_cnt     <= '0;
         q_filled     <= '0;
      end else if (Redirect) begin
         wr_ptr       <= '0;
         fill_ptr     <= '0;
         rd_ptr       <= '0;
         alloc_cnt    <= '0;
         unfilled_cnt <= '0;
         drop_cnt     <= redirect_drop;
         q_filled     <= '0;
      end else begin
         if (issue) begin
            wr_ptr           <= wr_ptr + 1'b1;
            q_filled[wr_ptr] <= 1'b0;
         end
         if (fill_ok) begin
            fill_ptr           <= fill_ptr + 1'b1;
            q_filled[fill_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr           <= rd_ptr + 1'b1;
            q_filled[rd_ptr] <= 1'b0;
         end
         if (drop_dec) begin
            drop_cnt <= drop_cnt - DROP_W'(1);
         end
         alloc_cnt    <= alloc_cnt + CNT_W'(issue) - CNT_W'(pop);
         unfilled_cnt <= unfilled_cnt + CNT_W'(issue) - CNT_W'(fill_ok);
      end
   end

   // Entry payloads. These need no reset because the filled flags gate
   // every use of them.
   always_ff @(posedge CLOCK) begin
      if (issue) begin
         q_pc[wr_ptr] <= PC_Cur;
      end
      if (fill_ok) begin
         q_instr[fill_ptr] <= IMEM_Rdata;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// ----------------------------------------------------------------------------
// Self-checking bench for if_fetch_unit. It models the PC register and an
// in-order instruction memory with random grant and latency. A reference
// model keeps the fetch queue as a list of {pc, instr, filled} records plus
// a count of stale responses still owed by the memory.
// ============================================================================
module tb_if_fetch_unit;

   localparam int DEPTH = 4;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic [31:0] PC_Cur;
   logic [31:0] PC_Next;
   logic        PC_Stall;
   logic        IMEM_Req;
   logic [31:0] IMEM_Addr;
   logic        IMEM_Gnt;
   logic        IMEM_Rvalid;
   logic [31:0] IMEM_Rdata;
   logic        Redirect;
   logic [31:0] Redirect_Target;
   logic        ID_Valid;
   logic        ID_Ready;
   logic [31:0] ID_Instr;
   logic [31:0] ID_PC;

   if_fetch_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .CLOCK           (CLOCK),
      .RESET           (RESET),
      .PC_Cur          (PC_Cur),
      .PC_Next         (PC_Next),
      .PC_Stall        (PC_Stall),
      .IMEM_Req        (IMEM_Req),
      .IMEM_Addr       (IMEM_Addr),
      .IMEM_Gnt        (IMEM_Gnt),
      .IMEM_Rvalid     (IMEM_Rvalid),
      .IMEM_Rdata      (IMEM_Rdata),
      .Redirect        (Redirect),
      .Redirect_Target (Redirect_Target),
      .ID_Valid        (ID_Valid),
      .ID_Ready        (ID_Ready),
      .ID_Instr        (ID_Instr),
      .ID_PC           (ID_PC)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          filled;
   } entry_t;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } mreq_t;

   entry_t mq[$];
   mreq_t  mem[$];
   int     drop_model = 0;
   int     cyc = 0;
   int     last_ready = -1;
   int     delivered = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   bit     rv_real;

   // Instruction word the memory returns for an address.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Drives one cycle of inputs: a directed warm-up, a queue-filling phase
   // with decode stalled, then fully random traffic with redirects.
   task automatic applyStimulus();
      int phase;
      phase = (cyc < 40) ? 0 : (cyc < 80) ? 1 : 2;
      IMEM_Gnt        = (phase < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ID_Ready        = (phase == 0) ? 1'b1 : (phase == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
      Redirect        = (phase == 2) && ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
         0:       Redirect_Target = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
         1:       Redirect_Target = 32'($urandom_range(0, 1023));
         default: Redirect_Target = $urandom;
      endcase
      rv_real     = 1'b0;
      IMEM_Rvalid = 1'b0;
      IMEM_Rdata  = $urandom;
      if (mem.size() > 0 && mem[0].ready <= cyc) begin
         rv_real     = 1'b1;
         IMEM_Rvalid = 1'b1;
         IMEM_Rdata  = imem_word(mem[0].addr);
      end else if (phase == 2 && mem.size() == 0 && $urandom_range(0, 4) == 0) begin
         IMEM_Rvalid = 1'b1;
      end
   endtask

   initial begin
      logic        exp_req;
      logic        exp_valid;
      logic        exp_stall;
      logic [31:0] exp_next;
      int          unfilled;
      int          lat;
      int          rdy;

      RESET = 1'b1;
      PC_Cur = 32'hFFFF_FFFC;
      IMEM_Gnt = 1'b1;
      IMEM_Rvalid = 1'b0;
      IMEM_Rdata = '0;
      Redirect = 1'b0;
      Redirect_Target = '0;
      ID_Ready = 1'b1;

      // Reset state, including a redirect asserted while in reset.
      for (int i = 0; i < 3; i++) begin
         @(negedge CLOCK);
         Redirect = (i == 2);
         #1;
         checkOutput("rst_req", 32'(IMEM_Req), 32'd0);
         checkOutput("rst_valid", 32'(ID_Valid), 32'd0);
         checkOutput("rst_stall", 32'(PC_Stall), 32'd1);
      end

      @(negedge CLOCK);
      RESET = 1'b0;
      Redirect = 1'b0;

      for (int c = 0; c < 1500; c++) begin
         if (c > 0) @(negedge CLOCK);
         applyStimulus();
         #1;

         exp_req   = !Redirect && (mq.size() < DEPTH);
         exp_valid = (mq.size() > 0) && mq[0].filled && !Redirect;
         exp_next  = Redirect ? {Redirect_Target[31:2], 2'b00} : PC_Cur + 32'd4;
         exp_stall = Redirect ? 1'b0 : !(exp_req && IMEM_Gnt);

         checkOutput("imem_req", 32'(IMEM_Req), 32'(exp_req));
         checkOutput("imem_addr", IMEM_Addr, PC_Cur);
         checkOutput("id_valid", 32'(ID_Valid), 32'(exp_valid));
         checkOutput("pc_next", PC_Next, exp_next);
         checkOutput("pc_stall", 32'(PC_Stall), 32'(exp_stall));
         if (exp_valid) begin
            checkOutput("id_pc", ID_PC, mq[0].pc);
            checkOutput("id_instr", ID_Instr, mq[0].instr);
         end

         @(posedge CLOCK);
         #1;

         // Memory side: consume the presented response, accept a grant.
         if (rv_real) void'(mem.pop_front());
         if (exp_req && IMEM_Gnt) begin
            lat = (cyc < 80) ? 1 : $urandom_range(1, 3);
            rdy = cyc + lat;
            if (rdy <= last_ready) rdy = last_ready + 1;
            last_ready = rdy;
            mem.push_back('{addr: PC_Cur, ready: rdy});
         end

         // Reference model of the fetch queue.
         if (Redirect) begin
            unfilled = 0;
            foreach (mq[k]) if (!mq[k].filled) unfilled++;
            drop_model += unfilled;
            if (IMEM_Rvalid && drop_model > 0) drop_model--;
            mq.delete();
         end else begin
            if (IMEM_Rvalid) begin
               if (drop_model > 0) begin
                  drop_model--;
               end else begin
                  for (int k = 0; k < mq.size(); k++) begin
                     if (!mq[k].filled) begin
                        mq[k].filled = 1'b1;
                        mq[k].instr  = IMEM_Rdata;
                        break;
                     end
                  end
               end
            end
            if (exp_valid && ID_Ready) begin
               void'(mq.pop_front());
               delivered++;
            end
            if (exp_req && IMEM_Gnt) mq.push_back('{pc: PC_Cur, instr: 32'h0, filled: 1'b0});
         end

         // PC register.
         if (!exp_stall) PC_Cur = exp_next;
         cyc++;
      end

      checkOutput("delivered_enough", 32'(delivered >= 30), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
